rr_mux_n: RTL and testbench

//   Parametrised, registered N:1 data multiplexer with per-channel valid/ready handshake.

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/rr_mux_n.sv | 106 ++++++++++
 tb/tb_rr_mux_n.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 round-robin / fixed-select mux.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Index width for n items. Returns 1 when n <= 2, so a port never ends up zero width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [N_CH-1:0] req_hi;
  logic [N_CH-1:0] pick;

  // Requests above ptr win first. If there are none, scanning wraps to the lowest requester.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < N_CH; i++)
      req_hi[i] = req[i] && (i > int'(ptr));
    pick = (|req_hi) ? req_hi : req;

    gnt     = '0;
    gnt_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
    gnt_any = |req;
  end

endmodule

// File: rtl/rr_mux_n.sv
// Registered N:1 stream mux with per-channel valid/ready handshakes.
// The selection mode is round-robin or fixed-select.
module rr_mux_n
  import mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch
);

  logic [N_CH-1:0][DATA_W-1:0] ch_data;
  logic [SEL_W-1:0]            rr_ptr;

  logic [N_CH-1:0]  rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;

  logic [N_CH-1:0]  fx_gnt;
  logic             fx_any;

  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic [DATA_W-1:0] win_data;

  assign ch_data = in_data;
  assign load    = !out_valid || out_ready;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Fixed select compares sel with each channel number. A sel value of N_CH or more
  // matches no channel, so no grant is issued.
  for (genvar i = 0; i < N_CH; i++) begin : g_fx
    assign fx_gnt[i] = in_valid[i] && (sel == SEL_W'(i));
  end
  assign fx_any = |fx_gnt;

  always_comb begin
    if (mode == MODE_FIXED) begin
      gnt     = fx_gnt;
      gnt_idx = sel;
      gnt_any = fx_any;
    end else begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end
  end

  // gnt is one-hot, so an AND-OR mux is enough and it avoids indexing by a variable.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CH; i++)
      win_data = win_data | (ch_data[i] & {DATA_W{gnt[i]}});
  end

  // Holding rst_n low keeps every input channel back. The handshake then starts cleanly
  // after reset is released.
  assign in_ready = gnt & {N_CH{load & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (load) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_ch    <= gnt_idx;
        rr_ptr    <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed test of rr_mux_n. One instance has 8 channels and one has 5 (non-power-of-2).
module tb_rr_mux_n;

  logic clk;
  logic rst_n;

  logic        mode8, out_valid8, out_ready8;
  logic [2:0]  sel8, out_ch8;
  logic [7:0]  in_valid8, in_ready8, out_data8;
  logic [63:0] in_data8;

  logic        mode5, out_valid5, out_ready5;
  logic [2:0]  sel5, out_ch5;
  logic [4:0]  in_valid5, in_ready5;
  logic [7:0]  out_data5;
  logic [39:0] in_data5;

  int checks;
  int failures;

  rr_mux_n #(.N_CH(8), .DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_ch(out_ch8)
  );

  rr_mux_n #(.N_CH(5), .DATA_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_ch(out_ch5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    mode8 = 1'b0; sel8 = '0; in_valid8 = '0; out_ready8 = 1'b1;
    mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1; in_data5 = '0;
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'h10 + 8'(i);

    step(); step();
    chk("rst_valid", 32'(out_valid8), 32'd0);
    chk("rst_data", 32'(out_data8), 32'd0);
    chk("rst_ch", 32'(out_ch8), 32'd0);
    chk("rst_ready", 32'(in_ready8), 32'd0);
    rst_n = 1'b1;

    // Round-robin with every channel valid
    in_valid8 = 8'hFF;
    #1 chk("rr_first_ready", 32'(in_ready8), 32'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("rr_full_ch%0d", k), 32'(out_ch8), 32'(k % 8));
      chk($sformatf("rr_full_data%0d", k), 32'(out_data8), 32'h10 + 32'(k % 8));
      chk($sformatf("rr_full_valid%0d", k), 32'(out_valid8), 32'd1);
    end

    // Reset asserted while a beat is held
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid8), 32'd0);
    chk("midrst_ready", 32'(in_ready8), 32'd0);
    chk("midrst_data", 32'(out_data8), 32'd0);
    rst_n = 1'b1;
    step();
    chk("postrst_ch", 32'(out_ch8), 32'd0);
    chk("postrst_data", 32'(out_data8), 32'h10);

    // Sparse requesters 2 and 7
    in_valid8 = 8'b1000_0100;
    #1 chk("sparse_ready0", 32'(in_ready8), 32'h04);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("sparse_ch%0d", k), 32'(out_ch8), (k % 2 == 0) ? 32'd2 : 32'd7);
      chk($sformatf("sparse_ready%0d", k + 1), 32'(in_ready8), (k % 2 == 0) ? 32'h80 : 32'h04);
    end

    // Backpressure on a beat from ch3
    in_data8[3*8 +: 8] = 8'hA5;
    in_valid8 = 8'h08;
    step();
    chk("bp_load_ch", 32'(out_ch8), 32'd3);
    chk("bp_load_data", 32'(out_data8), 32'hA5);
    out_ready8 = 1'b0;
    in_valid8 = 8'hFF;
    #1 chk("bp_ready_stall", 32'(in_ready8), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp_valid%0d", k), 32'(out_valid8), 32'd1);
      chk($sformatf("bp_data%0d", k), 32'(out_data8), 32'hA5);
      chk($sformatf("bp_ch%0d", k), 32'(out_ch8), 32'd3);
      chk($sformatf("bp_ready%0d", k), 32'(in_ready8), 32'd0);
    end
    out_ready8 = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready8), 32'h10);
    step();
    chk("bp_next_ch", 32'(out_ch8), 32'd4);
    chk("bp_next_data", 32'(out_data8), 32'h14);

    // Fixed select on ch3
    mode8 = 1'b1; sel8 = 3'd3;
    #1 chk("fx_ready", 32'(in_ready8), 32'h08);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fx_ch%0d", k), 32'(out_ch8), 32'd3);
      chk($sformatf("fx_data%0d", k), 32'(out_data8), 32'hA5);
    end
    in_valid8 = 8'hF7;
    #1 chk("fx_drop_ready", 32'(in_ready8), 32'd0);
    step();
    chk("fx_drop_valid", 32'(out_valid8), 32'd0);
    chk("fx_drop_ch_hold", 32'(out_ch8), 32'd3);
    chk("fx_drop_data_hold", 32'(out_data8), 32'hA5);
    mode8 = 1'b0;
    #1 chk("fx_to_rr_ready", 32'(in_ready8), 32'h10);
    step();
    chk("fx_to_rr_ch", 32'(out_ch8), 32'd4);
    chk("fx_to_rr_valid", 32'(out_valid8), 32'd1);

    // Five channels: an out-of-range sel is never granted
    mode5 = 1'b1; sel5 = 3'd6; in_valid5 = 5'h1F;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("n5_oor_ready%0d", k), 32'(in_ready5), 32'd0);
      step();
      chk($sformatf("n5_oor_valid%0d", k), 32'(out_valid5), 32'd0);
    end
    sel5 = 3'd7;
    step();
    chk("n5_oor7_valid", 32'(out_valid5), 32'd0);

    // Five channels: round-robin wraps from ch4 to ch0
    mode5 = 1'b0;
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h50 + 8'(i);
    in_valid5 = 5'b00010;
    step();
    chk("n5_seed_ch", 32'(out_ch5), 32'd1);
    in_valid5 = 5'b10001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("n5_wrap_ch%0d", k), 32'(out_ch5), (k == 1) ? 32'd0 : 32'd4);
      chk($sformatf("n5_wrap_data%0d", k), 32'(out_data5), (k == 1) ? 32'h50 : 32'h54);
    end

    // Five channels: sweep every data value through every channel
    mode5 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sel5 = 3'(c);
      in_valid5 = 5'(1 << c);
      for (int d = 0; d < 256; d++) begin
        in_data5[c*8 +: 8] = 8'(d);
        step();
        chk($sformatf("n5_sweep_c%0d_d%0d", c, d), {out_valid5, 8'(out_ch5), out_data5},
            {1'b1, 8'(c), 8'(d)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
